// File: rtl/noc_out_mux2_pkg.sv
// Shared NoC definitions for the output-stage multiplexer.
// - Default widths: flit data, virtual-channel id and router port-select.
// - Flit type codes carried in the top three data bits.
// - Active-high and active-low enable constants.
package noc_out_mux2_pkg;

  localparam int unsigned DATAW  = 67;
  localparam int unsigned VCHW   = 2;
  localparam int unsigned PORTW  = 5;
  localparam int unsigned TYPEW  = 3;

  // The type field sits in data bits [DATAW-1:DATAW-3]. The mux never decodes it.
  typedef enum logic [TYPEW-1:0] {
    FlitNone = 3'd0,
    FlitHead = 3'd1,
    FlitData = 3'd2,
    FlitTail = 3'd3
  } flit_type_e;

  localparam logic Enable   = 1'b1;
  localparam logic Disable  = 1'b0;
  localparam logic EnableN  = 1'b0;
  localparam logic DisableN = 1'b1;

endpackage

// File: rtl/noc_out_mux2_onehot_dec.sv
// One-hot select decoder for the 2:1 output mux.
// Ports:
//   sel_i   - router port select; only 'b00..01 and 'b00..10 are legal
//   pick0_o - input 0 selected
//   pick1_o - input 1 selected
//   none_o  - no legal selection (zero, both low bits, or any upper bit set)
module noc_out_mux2_onehot_dec
  import noc_out_mux2_pkg::*;
#(
  parameter int unsigned SEL_W = PORTW
) (
  input  logic [SEL_W-1:0] sel_i,
  output logic             pick0_o,
  output logic             pick1_o,
  output logic             none_o
);

  // Exact compares so that any stray upper bit makes the select illegal.
  localparam logic [SEL_W-1:0] Sel0 = SEL_W'(1);
  localparam logic [SEL_W-1:0] Sel1 = SEL_W'(2);

  always_comb begin
    pick0_o = (sel_i == Sel0);
    pick1_o = (sel_i == Sel1);
    none_o  = ~(pick0_o | pick1_o);
  end

endmodule

// File: rtl/noc_out_mux2.sv
// Registered 2:1 flit multiplexer for a NoC router output port.
// The flit of the input chosen by a one-hot select is registered onto the output
// link one cycle later. Data and VC id registers only load on a forwarded valid
// flit, so the output link does not toggle on idle or unselected cycles.
// Ports:
//   clk, rst_                  - clock (rising edge), async active-low reset
//   idata_0/ivalid_0/ivch_0    - input 0 flit, valid, VC id
//   idata_1/ivalid_1/ivch_1    - input 1 flit, valid, VC id
//   sel                        - one-hot select (bit0 = input 0, bit1 = input 1)
//   odata/ovalid/ovch          - registered output flit, valid, VC id
module noc_out_mux2
  import noc_out_mux2_pkg::*;
#(
  parameter int unsigned DATA_W = DATAW,
  parameter int unsigned VCH_W  = VCHW,
  parameter int unsigned SEL_W  = PORTW
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [DATA_W-1:0] idata_0,
  input  logic              ivalid_0,
  input  logic [VCH_W-1:0]  ivch_0,
  input  logic [DATA_W-1:0] idata_1,
  input  logic              ivalid_1,
  input  logic [VCH_W-1:0]  ivch_1,
  input  logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] odata,
  output logic              ovalid,
  output logic [VCH_W-1:0]  ovch
);

  logic pick0, pick1, none;

  noc_out_mux2_onehot_dec #(
    .SEL_W (SEL_W)
  ) u_dec (
    .sel_i   (sel),
    .pick0_o (pick0),
    .pick1_o (pick1),
    .none_o  (none)
  );

  logic [DATA_W-1:0] odata_d, odata_q;
  logic              ovalid_d, ovalid_q;
  logic [VCH_W-1:0]  ovch_d, ovch_q;
  logic              capture;

  always_comb begin
    capture  = Disable;
    odata_d  = odata_q;
    ovch_d   = ovch_q;
    ovalid_d = Disable;
    if (!none) begin
      capture  = (pick0 & ivalid_0) | (pick1 & ivalid_1);
      ovalid_d = capture;
    end
    // Hold data/VC on idle cycles to keep the link quiet.
    if (capture) begin
      odata_d = pick1 ? idata_1 : idata_0;
      ovch_d  = pick1 ? ivch_1  : ivch_0;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      odata_q  <= '0;
      ovalid_q <= Disable;
      ovch_q   <= '0;
    end else begin
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      ovch_q   <= ovch_d;
    end
  end

  assign odata  = odata_q;
  assign ovalid = ovalid_q;
  assign ovch   = ovch_q;

endmodule

// File: tb/tb_noc_out_mux2.sv
// Directed self-checking bench for noc_out_mux2.
module tb_noc_out_mux2;
  import noc_out_mux2_pkg::*;

  localparam int unsigned DW = 67;
  localparam int unsigned VW = 2;
  localparam int unsigned SW = 5;

  logic          clk;
  logic          rst_;
  logic [DW-1:0] idata_0, idata_1;
  logic          ivalid_0, ivalid_1;
  logic [VW-1:0] ivch_0, ivch_1;
  logic [SW-1:0] sel;
  logic [DW-1:0] odata;
  logic          ovalid;
  logic [VW-1:0] ovch;

  int total;
  int bad;

  noc_out_mux2 #(
    .DATA_W (DW),
    .VCH_W  (VW),
    .SEL_W  (SW)
  ) dut (
    .clk      (clk),
    .rst_     (rst_),
    .idata_0  (idata_0),
    .ivalid_0 (ivalid_0),
    .ivch_0   (ivch_0),
    .idata_1  (idata_1),
    .ivalid_1 (ivalid_1),
    .ivch_1   (ivch_1),
    .sel      (sel),
    .odata    (odata),
    .ovalid   (ovalid),
    .ovch     (ovch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk(input logic [2:0] t, input int a, input int b);
    return {t, 32'(a), 32'(b)};
  endfunction

  function automatic logic [DW-1:0] rnd_flit();
    return {3'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  // Inputs are driven 1 time unit after a rising edge; outputs sampled 1 unit after the next.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idata_0  = rnd_flit();
    idata_1  = rnd_flit();
    ivalid_0 = 1'b1;
    ivalid_1 = 1'b1;
    ivch_0   = 2'd3;
    ivch_1   = 2'd1;
    sel      = 5'b00001;
    rst_     = 1'b1;
    step();
    step();
    // Outputs are non-zero now; drop reset between edges.
    #2;
    rst_ = 1'b0;
    #1;
    total++;
    if (odata !== '0 || ovalid !== 1'b0 || ovch !== 2'd0) begin
      bad++;
      $display("FAIL reset_async: odata=%h ovalid=%b ovch=%0d required 0/0/0",
               odata, ovalid, ovch);
    end
    step();
    total++;
    if (odata !== '0 || ovalid !== 1'b0 || ovch !== 2'd0) begin
      bad++;
      $display("FAIL reset_held: odata=%h ovalid=%b ovch=%0d required 0/0/0",
               odata, ovalid, ovch);
    end
    rst_ = 1'b1;
  endtask

  task automatic test_sel1_head();
    logic [DW-1:0] f;
    f        = mk(FlitHead, 0, 32'h04);
    idata_1  = f;
    ivalid_1 = 1'b1;
    ivch_1   = 2'd2;
    idata_0  = mk(FlitHead, 0, 9);
    ivalid_0 = 1'b1;
    ivch_0   = 2'd1;
    sel      = 5'b00010;
    step();
    total++;
    if (odata !== f || ovalid !== 1'b1 || ovch !== 2'd2) begin
      bad++;
      $display("FAIL sel1_head: odata=%h ovalid=%b ovch=%0d required %h/1/2",
               odata, ovalid, ovch, f);
    end
  endtask

  task automatic test_packets();
    logic [DW-1:0] f, tail;
    logic [2:0]    t;
    int            errs;
    sel  = 5'b00010;
    errs = 0;
    tail = '0;
    for (int p = 0; p < 10; p++) begin
      for (int i = 0; i < 22; i++) begin
        t = (i == 0) ? FlitHead : (i == 21) ? FlitTail : FlitData;
        f = mk(t, p, 32'h1000 + i);
        idata_1  = f;
        ivalid_1 = 1'b1;
        ivch_1   = 2'(p);
        idata_0  = rnd_flit();
        ivalid_0 = 1'b1;
        ivch_0   = 2'(p + 1);
        step();
        total++;
        if (odata !== f || ovalid !== 1'b1 || ovch !== 2'(p)) begin
          bad++;
          $display("FAIL pkt_flit p=%0d i=%0d: odata=%h ovalid=%b ovch=%0d required %h/1/%0d",
                   p, i, odata, ovalid, ovch, f, p);
        end
        tail = f;
      end
      for (int k = 0; k < 7; k++) begin
        idata_1  = rnd_flit();
        ivalid_1 = 1'b0;
        ivch_1   = 2'(k);
        step();
        total++;
        if (odata !== tail || ovalid !== 1'b0 || ovch !== 2'(p)) begin
          bad++;
          $display("FAIL pkt_idle p=%0d k=%0d: odata=%h ovalid=%b ovch=%0d required %h/0/%0d",
                   p, k, odata, ovalid, ovch, tail, p);
        end
      end
    end
  endtask

  task automatic test_sel0();
    logic [DW-1:0] f;
    sel      = 5'b00001;
    ivalid_1 = 1'b1;
    ivch_1   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      f        = mk(FlitData, 32'hA5A5_0000 + i, 32'h5A5A_0000 + i);
      idata_0  = f;
      ivalid_0 = 1'b1;
      ivch_0   = 2'd3 - 2'(i);
      idata_1  = ~f;
      step();
      total++;
      if (odata !== f || ovalid !== 1'b1 || ovch !== 2'd3 - 2'(i)) begin
        bad++;
        $display("FAIL sel0_fwd i=%0d: odata=%h ovalid=%b ovch=%0d required %h/1/%0d",
                 i, odata, ovalid, ovch, f, 3 - i);
      end
    end
  endtask

  task automatic test_illegal();
    logic [DW-1:0] held;
    logic [SW-1:0] bad_sel [3];
    bad_sel[0] = 5'b00000;
    bad_sel[1] = 5'b00011;
    bad_sel[2] = 5'b00100;
    held     = mk(FlitTail, 77, 88);
    sel      = 5'b00001;
    idata_0  = held;
    ivalid_0 = 1'b1;
    ivch_0   = 2'd1;
    step();
    for (int i = 0; i < 3; i++) begin
      sel      = bad_sel[i];
      idata_0  = rnd_flit();
      idata_1  = rnd_flit();
      ivalid_0 = 1'b1;
      ivalid_1 = 1'b1;
      ivch_0   = 2'd2;
      ivch_1   = 2'd3;
      step();
      total++;
      if (odata !== held || ovalid !== 1'b0 || ovch !== 2'd1) begin
        bad++;
        $display("FAIL illegal_sel %b: odata=%h ovalid=%b ovch=%0d required %h/0/1",
                 bad_sel[i], odata, ovalid, ovch, held);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] f;
    logic [2:0]    t;
    sel      = 5'b00010;
    ivalid_0 = 1'b0;
    for (int i = 0; i <= 11; i++) begin
      t = (i == 0) ? FlitHead : FlitData;
      idata_1  = mk(t, 5, i);
      ivalid_1 = 1'b1;
      ivch_1   = 2'd3;
      step();
    end
    // DATA flit 10 (index 11) is on the output; assert reset mid-cycle.
    #2;
    rst_ = 1'b0;
    #1;
    total++;
    if (odata !== '0 || ovalid !== 1'b0 || ovch !== 2'd0) begin
      bad++;
      $display("FAIL reset_mid: odata=%h ovalid=%b ovch=%0d required 0/0/0",
               odata, ovalid, ovch);
    end
    step();
    rst_ = 1'b1;
    f        = mk(FlitData, 6, 12);
    idata_1  = f;
    ivalid_1 = 1'b1;
    ivch_1   = 2'd1;
    step();
    total++;
    if (odata !== f || ovalid !== 1'b1 || ovch !== 2'd1) begin
      bad++;
      $display("FAIL reset_release: odata=%h ovalid=%b ovch=%0d required %h/1/1",
               odata, ovalid, ovch, f);
    end
  endtask

  task automatic test_back_to_back_switch();
    logic [DW-1:0] a, b;
    a        = mk(FlitHead, 1, 1);
    b        = mk(FlitTail, 2, 2);
    idata_0  = a;
    ivch_0   = 2'd0;
    idata_1  = b;
    ivch_1   = 2'd3;
    ivalid_0 = 1'b1;
    ivalid_1 = 1'b1;
    sel      = 5'b00001;
    step();
    total++;
    if (odata !== a || ovalid !== 1'b1 || ovch !== 2'd0) begin
      bad++;
      $display("FAIL switch_a: odata=%h ovalid=%b ovch=%0d required %h/1/0",
               odata, ovalid, ovch, a);
    end
    sel = 5'b00010;
    step();
    total++;
    if (odata !== b || ovalid !== 1'b1 || ovch !== 2'd3) begin
      bad++;
      $display("FAIL switch_b: odata=%h ovalid=%b ovch=%0d required %h/1/3",
               odata, ovalid, ovch, b);
    end
    ivalid_1 = 1'b0;
    step();
    total++;
    if (odata !== b || ovalid !== 1'b0 || ovch !== 2'd3) begin
      bad++;
      $display("FAIL sel_invalid_hold: odata=%h ovalid=%b ovch=%0d required %h/0/3",
               odata, ovalid, ovch, b);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_     = 1'b0;
    idata_0  = '0;
    idata_1  = '0;
    ivalid_0 = 1'b0;
    ivalid_1 = 1'b0;
    ivch_0   = '0;
    ivch_1   = '0;
    sel      = '0;
    #3;
    test_reset();
    test_sel1_head();
    test_packets();
    test_sel0();
    test_illegal();
    test_back_to_back_switch();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
